// File: rtl/reset_controller.sv
// ---------------------------------------------------------------------------
// reset_controller
//
// Purpose:
//   Central reset/game-over sequencer for the game logic. The raw reset
//   push-button is synchronised and debounced. A debounced press produces a
//   stretched gameReset pulse. Collision flags from the game move the
//   controller into a game-over state that latches which source caused it.
//   Game-over is left by a press, or on a timeout when AUTO_RESTART is set.
//
// Ports:
//   clock       in   system clock, everything on the rising edge
//   reset       in   synchronous active-high controller reset
//   resetHW     in   raw asynchronous push-button, active-low (1 = released)
//   collision   in   [NUM_SOURCES] per-source collision flags, active-high
//   gameReset   out  active-high stretched reset to the game logic
//   gameOver    out  high while the controller is in game-over
//   cause       out  [NUM_SOURCES] collision bits latched on game-over entry
//   resetCount  out  [8] number of completed reset pulses, wraps 255 -> 0
// ---------------------------------------------------------------------------
module reset_controller #(
  parameter int NUM_SOURCES     = 2,
  parameter int DEBOUNCE_CYCLES = 500000,
  parameter int PULSE_CYCLES    = 16,
  parameter int AUTO_RESTART    = 0,
  parameter int GAMEOVER_CYCLES = 50000000
) (
  input  logic                   clock,
  input  logic                   reset,
  input  logic                   resetHW,
  input  logic [NUM_SOURCES-1:0] collision,
  output logic                   gameReset,
  output logic                   gameOver,
  output logic [NUM_SOURCES-1:0] cause,
  output logic [7:0]             resetCount
);

  // Counter widths sized to hold their largest terminal count.
  localparam int DEB_W   = $clog2(DEBOUNCE_CYCLES + 1);
  localparam int PULSE_W = $clog2(PULSE_CYCLES + 1);
  localparam int GO_W    = $clog2(GAMEOVER_CYCLES + 1);

  // Terminal values: each counter stops one short of its cycle count because
  // the transition itself happens on the final counted edge.
  localparam logic [DEB_W-1:0]   DEB_LAST   = DEB_W'(DEBOUNCE_CYCLES - 1);
  localparam logic [PULSE_W-1:0] PULSE_LAST = PULSE_W'(PULSE_CYCLES - 1);
  localparam logic [GO_W-1:0]    GO_LAST    = GO_W'(GAMEOVER_CYCLES - 1);

  typedef enum logic [1:0] {
    RESET_PULSE = 2'd0,
    RUN         = 2'd1,
    GAME_OVER   = 2'd2
  } state_t;

  // -------------------------------------------------------------------------
  // Button synchroniser. Both flops reset to the released level so that a
  // controller reset never looks like a press.
  // -------------------------------------------------------------------------
  logic sync1_q;
  logic sync2_q;

  always_ff @(posedge clock) begin
    if (reset) begin
      sync1_q <= 1'b1;
      sync2_q <= 1'b1;
    end else begin
      sync1_q <= resetHW;
      sync2_q <= sync1_q;
    end
  end

  // -------------------------------------------------------------------------
  // Debouncer. The accepted level only follows the synchronised level after
  // it has disagreed for DEBOUNCE_CYCLES consecutive cycles; any agreement
  // in between starts the count again from zero.
  // -------------------------------------------------------------------------
  logic             debLevel_q;
  logic             debLevel_d;
  logic [DEB_W-1:0] debCnt_q;
  logic [DEB_W-1:0] debCnt_d;
  logic             pressEvent_q;

  always_comb begin
    debLevel_d = debLevel_q;
    debCnt_d   = '0;
    if (sync2_q != debLevel_q) begin
      if (debCnt_q == DEB_LAST) begin
        debLevel_d = sync2_q;
        debCnt_d   = '0;
      end else begin
        debCnt_d = debCnt_q + 1'b1;
      end
    end
  end

  // The press event is high for exactly the first cycle in which the accepted
  // level reads 0; a release produces nothing.
  always_ff @(posedge clock) begin
    if (reset) begin
      debLevel_q   <= 1'b1;
      debCnt_q     <= '0;
      pressEvent_q <= 1'b0;
    end else begin
      debLevel_q   <= debLevel_d;
      debCnt_q     <= debCnt_d;
      pressEvent_q <= debLevel_q & ~debLevel_d;
    end
  end

  // -------------------------------------------------------------------------
  // Controller state and counters.
  // -------------------------------------------------------------------------
  state_t                 state_q;
  state_t                 state_d;
  logic [PULSE_W-1:0]     pulseCnt_q;
  logic [PULSE_W-1:0]     pulseCnt_d;
  logic [GO_W-1:0]        goCnt_q;
  logic [GO_W-1:0]        goCnt_d;
  logic [NUM_SOURCES-1:0] cause_q;
  logic [NUM_SOURCES-1:0] cause_d;
  logic [7:0]             resetCount_q;
  logic [7:0]             resetCount_d;
  logic                   gameReset_q;
  logic                   gameReset_d;
  logic                   gameOver_q;
  logic                   gameOver_d;

  // Next-state logic. The pulse runs to completion regardless of presses or
  // collisions. In RUN a press takes priority over a simultaneous collision.
  // In game-over further collisions are ignored so the first cause is kept.
  always_comb begin
    state_d      = state_q;
    pulseCnt_d   = pulseCnt_q;
    goCnt_d      = goCnt_q;
    cause_d      = cause_q;
    resetCount_d = resetCount_q;

    case (state_q)
      RESET_PULSE: begin
        cause_d = '0;
        goCnt_d = '0;
        if (pulseCnt_q == PULSE_LAST) begin
          state_d      = RUN;
          pulseCnt_d   = '0;
          resetCount_d = resetCount_q + 1'b1;
        end else begin
          pulseCnt_d = pulseCnt_q + 1'b1;
        end
      end

      RUN: begin
        pulseCnt_d = '0;
        goCnt_d    = '0;
        if (pressEvent_q) begin
          state_d = RESET_PULSE;
          cause_d = '0;
        end else if (|collision) begin
          state_d = GAME_OVER;
          cause_d = collision;
        end
      end

      GAME_OVER: begin
        pulseCnt_d = '0;
        if (pressEvent_q) begin
          state_d = RESET_PULSE;
          cause_d = '0;
          goCnt_d = '0;
        end else if (AUTO_RESTART != 0) begin
          if (goCnt_q == GO_LAST) begin
            state_d = RESET_PULSE;
            cause_d = '0;
            goCnt_d = '0;
          end else begin
            goCnt_d = goCnt_q + 1'b1;
          end
        end
      end

      default: begin
        state_d    = RESET_PULSE;
        pulseCnt_d = '0;
        goCnt_d    = '0;
        cause_d    = '0;
      end
    endcase

    // Outputs are decoded from the next state so that they change on the
    // same edge as the state register.
    gameReset_d = (state_d == RESET_PULSE);
    gameOver_d  = (state_d == GAME_OVER);
  end

  // State register. A controller reset drops everything back to the start of
  // a fresh, full-length pulse.
  always_ff @(posedge clock) begin
    if (reset) begin
      state_q      <= RESET_PULSE;
      pulseCnt_q   <= '0;
      goCnt_q      <= '0;
      cause_q      <= '0;
      resetCount_q <= '0;
      gameReset_q  <= 1'b1;
      gameOver_q   <= 1'b0;
    end else begin
      state_q      <= state_d;
      pulseCnt_q   <= pulseCnt_d;
      goCnt_q      <= goCnt_d;
      cause_q      <= cause_d;
      resetCount_q <= resetCount_d;
      gameReset_q  <= gameReset_d;
      gameOver_q   <= gameOver_d;
    end
  end

  assign gameReset  = gameReset_q;
  assign gameOver   = gameOver_q;
  assign cause      = cause_q;
  assign resetCount = resetCount_q;

endmodule

// File: tb/tb_reset_controller.sv
// ---------------------------------------------------------------------------
// tb_reset_controller
//
// Purpose:
//   Directed self-checking bench for reset_controller. A main instance uses
//   AUTO_RESTART=0 and a second instance uses AUTO_RESTART=1. Both use small
//   parameters (2 sources, debounce 4, pulse 3, game-over 8). Inputs are
//   driven and outputs sampled on the falling clock edge.
//
//   Press timing with these parameters, counted in rising edges after
//   resetHW drops: 2 synchroniser edges and 4 debounce edges, then one edge
//   to enter the pulse. gameReset is therefore first seen high 7 edges later.
// ---------------------------------------------------------------------------
module tb_reset_controller;

  logic       clock = 1'b0;
  logic       reset;
  logic       resetHW;
  logic [1:0] collision;
  logic       gameReset;
  logic       gameOver;
  logic [1:0] cause;
  logic [7:0] resetCount;

  logic [1:0] autoCollision;
  logic       autoGameReset;
  logic       autoGameOver;
  logic [1:0] autoCause;
  logic [7:0] autoResetCount;

  int checks = 0;
  int errors = 0;

  always #5 clock = ~clock;

  reset_controller #(
    .NUM_SOURCES(2), .DEBOUNCE_CYCLES(4), .PULSE_CYCLES(3),
    .AUTO_RESTART(0), .GAMEOVER_CYCLES(8)
  ) dut (
    .clock(clock), .reset(reset), .resetHW(resetHW), .collision(collision),
    .gameReset(gameReset), .gameOver(gameOver), .cause(cause),
    .resetCount(resetCount)
  );

  reset_controller #(
    .NUM_SOURCES(2), .DEBOUNCE_CYCLES(4), .PULSE_CYCLES(3),
    .AUTO_RESTART(1), .GAMEOVER_CYCLES(8)
  ) dutAuto (
    .clock(clock), .reset(reset), .resetHW(resetHW), .collision(autoCollision),
    .gameReset(autoGameReset), .gameOver(autoGameOver), .cause(autoCause),
    .resetCount(autoResetCount)
  );

  // Measures the main instance's gameReset pulse: falling edges waited until
  // it is seen high, then how many consecutive falling edges it stays high.
  // Both loops are bounded; a timeout shows up as a wrong latency or width.
  task automatic countPulse(output int latency, output int width);
    latency = 0;
    while (gameReset !== 1'b1 && latency < 50) begin
      @(negedge clock);
      latency++;
    end
    width = 0;
    while (gameReset === 1'b1 && width < 50) begin
      width++;
      @(negedge clock);
    end
  endtask

  // Idles for n cycles, noting whether gameReset was ever seen high.
  task automatic waitQuiet(input int n, output bit sawPulse);
    sawPulse = 1'b0;
    repeat (n) begin
      @(negedge clock);
      if (gameReset !== 1'b0) sawPulse = 1'b1;
    end
  endtask

  task automatic test_reset();
    int lat;
    int w;
    reset = 1'b1; resetHW = 1'b1; collision = 2'b00; autoCollision = 2'b00;
    repeat (2) @(negedge clock);
    checks++;
    if ({gameReset, gameOver, cause, resetCount} !== {1'b1, 1'b0, 2'b00, 8'd0}) begin
      errors++;
      $display("[TB] FAIL reset_state: got gr=%b go=%b cause=%b cnt=%0d, expected gr=1 go=0 cause=00 cnt=0",
               gameReset, gameOver, cause, resetCount);
    end
    checks++;
    if (autoResetCount !== 8'd0) begin
      errors++;
      $display("[TB] FAIL auto_reset_count: got %0d expected 0", autoResetCount);
    end
    reset = 1'b0;
    countPulse(lat, w);
    checks++;
    if (lat !== 0 || w !== 3) begin
      errors++;
      $display("[TB] FAIL release_pulse: got latency=%0d width=%0d, expected latency=0 width=3", lat, w);
    end
    checks++;
    if (resetCount !== 8'd1 || gameOver !== 1'b0) begin
      errors++;
      $display("[TB] FAIL release_count: got cnt=%0d go=%b, expected cnt=1 go=0", resetCount, gameOver);
    end
  endtask

  task automatic test_auto_restart();
    int len;
    int w;
    autoCollision = 2'b01;
    @(negedge clock);
    autoCollision = 2'b00;
    checks++;
    if (autoGameOver !== 1'b1 || autoCause !== 2'b01) begin
      errors++;
      $display("[TB] FAIL auto_enter: got go=%b cause=%b, expected go=1 cause=01", autoGameOver, autoCause);
    end
    len = 0;
    while (autoGameOver === 1'b1 && len < 50) begin
      len++;
      @(negedge clock);
    end
    checks++;
    if (len !== 8) begin
      errors++;
      $display("[TB] FAIL auto_hold: got %0d cycles expected 8", len);
    end
    w = 0;
    while (autoGameReset === 1'b1 && w < 50) begin
      w++;
      @(negedge clock);
    end
    checks++;
    if (w !== 3) begin
      errors++;
      $display("[TB] FAIL auto_pulse: got width %0d expected 3", w);
    end
    checks++;
    if (autoResetCount !== 8'd2 || autoCause !== 2'b00 || gameOver !== 1'b0) begin
      errors++;
      $display("[TB] FAIL auto_after: got cnt=%0d cause=%b mainGo=%b, expected cnt=2 cause=00 mainGo=0",
               autoResetCount, autoCause, gameOver);
    end
  endtask

  task automatic test_glitch();
    bit saw;
    resetHW = 1'b0;
    repeat (3) @(negedge clock);
    resetHW = 1'b1;
    waitQuiet(12, saw);
    checks++;
    if (saw !== 1'b0 || resetCount !== 8'd1) begin
      errors++;
      $display("[TB] FAIL glitch: got pulse=%b cnt=%0d, expected pulse=0 cnt=1", saw, resetCount);
    end
  endtask

  task automatic test_press();
    int lat;
    int w;
    bit saw;
    resetHW = 1'b0;
    countPulse(lat, w);
    resetHW = 1'b1;
    checks++;
    if (lat !== 7 || w !== 3) begin
      errors++;
      $display("[TB] FAIL press_pulse: got latency=%0d width=%0d, expected latency=7 width=3", lat, w);
    end
    checks++;
    if (resetCount !== 8'd2) begin
      errors++;
      $display("[TB] FAIL press_count: got %0d expected 2", resetCount);
    end
    waitQuiet(12, saw);
    checks++;
    if (saw !== 1'b0) begin
      errors++;
      $display("[TB] FAIL release_event: got pulse=%b expected 0", saw);
    end
  endtask

  task automatic test_collision();
    int lat;
    int w;
    bit saw;
    collision = 2'b10;
    @(negedge clock);
    collision = 2'b00;
    checks++;
    if (gameOver !== 1'b1 || cause !== 2'b10 || gameReset !== 1'b0) begin
      errors++;
      $display("[TB] FAIL collision_enter: got go=%b cause=%b gr=%b, expected go=1 cause=10 gr=0",
               gameOver, cause, gameReset);
    end
    collision = 2'b01;
    @(negedge clock);
    collision = 2'b00;
    waitQuiet(12, saw);
    checks++;
    if (gameOver !== 1'b1 || cause !== 2'b10 || saw !== 1'b0) begin
      errors++;
      $display("[TB] FAIL collision_hold: got go=%b cause=%b pulse=%b, expected go=1 cause=10 pulse=0",
               gameOver, cause, saw);
    end
    resetHW = 1'b0;
    countPulse(lat, w);
    resetHW = 1'b1;
    checks++;
    if (lat !== 7 || w !== 3) begin
      errors++;
      $display("[TB] FAIL gameover_press: got latency=%0d width=%0d, expected latency=7 width=3", lat, w);
    end
    checks++;
    if (gameOver !== 1'b0 || cause !== 2'b00 || resetCount !== 8'd3) begin
      errors++;
      $display("[TB] FAIL gameover_exit: got go=%b cause=%b cnt=%0d, expected go=0 cause=00 cnt=3",
               gameOver, cause, resetCount);
    end
    waitQuiet(12, saw);
  endtask

  task automatic test_press_and_collision();
    bit saw;
    resetHW = 1'b0;
    // The press event is sampled on the 7th rising edge, so the collision is
    // driven for exactly that edge.
    repeat (6) @(negedge clock);
    collision = 2'b01;
    @(negedge clock);
    collision = 2'b00;
    checks++;
    if (gameReset !== 1'b1 || gameOver !== 1'b0 || cause !== 2'b00) begin
      errors++;
      $display("[TB] FAIL press_wins: got gr=%b go=%b cause=%b, expected gr=1 go=0 cause=00",
               gameReset, gameOver, cause);
    end
    repeat (3) @(negedge clock);
    resetHW = 1'b1;
    checks++;
    if (gameReset !== 1'b0 || gameOver !== 1'b0 || resetCount !== 8'd4) begin
      errors++;
      $display("[TB] FAIL press_wins_after: got gr=%b go=%b cnt=%0d, expected gr=0 go=0 cnt=4",
               gameReset, gameOver, resetCount);
    end
    waitQuiet(12, saw);
  endtask

  task automatic test_reset_in_gameover();
    int lat;
    int w;
    collision = 2'b11;
    @(negedge clock);
    collision = 2'b00;
    checks++;
    if (gameOver !== 1'b1 || cause !== 2'b11) begin
      errors++;
      $display("[TB] FAIL both_sources: got go=%b cause=%b, expected go=1 cause=11", gameOver, cause);
    end
    repeat (2) @(negedge clock);
    reset = 1'b1;
    @(negedge clock);
    reset = 1'b0;
    checks++;
    if ({gameReset, gameOver, cause, resetCount} !== {1'b1, 1'b0, 2'b00, 8'd0}) begin
      errors++;
      $display("[TB] FAIL gameover_reset: got gr=%b go=%b cause=%b cnt=%0d, expected gr=1 go=0 cause=00 cnt=0",
               gameReset, gameOver, cause, resetCount);
    end
    countPulse(lat, w);
    checks++;
    if (lat !== 0 || w !== 3 || resetCount !== 8'd1) begin
      errors++;
      $display("[TB] FAIL gameover_reset_pulse: got latency=%0d width=%0d cnt=%0d, expected 0 3 1",
               lat, w, resetCount);
    end
  endtask

  task automatic test_reset_mid_pulse();
    int lat;
    int w;
    reset = 1'b1;
    @(negedge clock);
    reset = 1'b0;
    @(negedge clock);
    reset = 1'b1;
    @(negedge clock);
    reset = 1'b0;
    countPulse(lat, w);
    checks++;
    if (lat !== 0 || w !== 3 || resetCount !== 8'd1) begin
      errors++;
      $display("[TB] FAIL mid_pulse_reset: got latency=%0d width=%0d cnt=%0d, expected 0 3 1",
               lat, w, resetCount);
    end
  endtask

  initial begin
    test_reset();
    test_auto_restart();
    test_glitch();
    test_press();
    test_collision();
    test_press_and_collision();
    test_reset_in_gameover();
    test_reset_mid_pulse();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

  // Watchdog so the run always ends even if a wait misbehaves.
  initial begin
    #200000;
    $display("[TB] FAIL watchdog: got timeout, expected completion");
    $fatal(1, "[TB] watchdog expired");
  end

endmodule

// File: doc/reset_controller.md
RESET_CONTROLLER -- requirements
Module: reset_controller

Interface
REQ-001 SHALL have parameter NUM_SOURCES, default 2: number of independent collision/fault inputs.
REQ-002 SHALL have parameter DEBOUNCE_CYCLES, default 500000: consecutive stable cycles required before the button level is accepted.
REQ-003 SHALL have parameter PULSE_CYCLES, default 16: width of the gameReset pulse in clock cycles.
REQ-004 SHALL have parameter AUTO_RESTART, default 0: 0 = stay in game-over until the button is pressed; 1 = restart automatically.
REQ-005 SHALL have parameter GAMEOVER_CYCLES, default 50000000: game-over hold time when AUTO_RESTART=1.
REQ-006 SHALL have port: clock  input  1  system clock, all logic on the rising edge.
REQ-007 SHALL have port: reset  input  1  synchronous, active-high controller reset.
REQ-008 SHALL have port: resetHW  input  1  raw asynchronous push-button, active-low (1 = released).
REQ-009 SHALL have port: collision  input  NUM_SOURCES  per-source collision flags, active-high, synchronous to clock.
REQ-010 SHALL have port: gameReset  output  1  active-high stretched reset to the game logic.
REQ-011 SHALL have port: gameOver  output  1  high while in GAME_OVER.
REQ-012 SHALL have port: cause  output  NUM_SOURCES  collision bits latched on game-over entry.
REQ-013 SHALL have port: resetCount  output  8  number of completed RESET_PULSE entries, wraps 255->0.

Function
REQ-014 SHALL pass resetHW through a 2-flop synchroniser before any other use.
REQ-015 SHALL update the debounced level only after the synchronised level has differed from it for DEBOUNCE_CYCLES consecutive cycles; any reversion clears the stability counter.
REQ-016 SHALL generate a one-cycle press event in the cycle the debounced level goes 1->0; no event on release.
REQ-017 SHALL size all counters as $clog2(max+1) bits; no counter may overflow or wrap, except resetCount.
REQ-018 SHALL implement states RESET_PULSE, RUN, GAME_OVER.
REQ-019 RESET_PULSE: gameReset=1; pulse counter increments each cycle; after PULSE_CYCLES cycles, move to RUN and increment resetCount.
REQ-020 RUN: gameReset=0; press event -> RESET_PULSE with cause cleared; else any collision bit set -> GAME_OVER with cause <= collision.
REQ-021 RUN, press event and collision in the same cycle: press wins, cause cleared, no GAME_OVER.
REQ-022 GAME_OVER: gameOver=1, gameReset=0, cause held; further collisions ignored; press event -> RESET_PULSE.
REQ-023 GAME_OVER with AUTO_RESTART=1: after GAMEOVER_CYCLES cycles with no press event -> RESET_PULSE; a press event exits earlier.
REQ-024 RESET_PULSE: collisions and press events ignored; the pulse is never shortened or restarted.
REQ-025 Latency: gameReset SHALL rise on the clock edge after the press event; gameOver SHALL rise on the clock edge after collision is sampled in RUN.
REQ-026 All outputs SHALL be registered.

Reset
REQ-027 reset=1 at an edge SHALL force: state RESET_PULSE, all counters 0, cause 0, resetCount 0, synchroniser and debounced level 1, gameReset=1, gameOver=0.
REQ-028 Reset asserted mid-pulse or mid-game-over SHALL restart a full PULSE_CYCLES pulse once reset is released; no counter value may be retained.

Verification (NUM_SOURCES=2, DEBOUNCE_CYCLES=4, PULSE_CYCLES=3, GAMEOVER_CYCLES=8, AUTO_RESTART=0 unless stated)
REQ-029 Release reset -> gameReset=1 for exactly 3 cycles, then 0; resetCount=1.
REQ-030 In RUN, resetHW low for 3 cycles then high -> no press event, gameReset stays 0; resetHW low for 10 cycles -> gameReset=1 for 3 cycles, resetCount increments.
REQ-031 In RUN, collision=2'b10 for 1 cycle -> gameOver=1, cause=2'b10 until a debounced press; after the press, gameReset pulses for 3 cycles and cause=0.
REQ-032 In RUN, press event and collision=2'b01 in the same cycle -> RESET_PULSE, gameOver stays 0, cause=0.
REQ-033 AUTO_RESTART=1, collision=2'b01 -> gameOver=1 for 8 cycles, then gameReset=1 for 3 cycles.
REQ-034 reset asserted for 1 cycle during GAME_OVER -> gameOver=0, cause=0, resetCount=0, gameReset=1 for 3 cycles, then RUN.
